uart_rx: RTL and testbench

Oversampling UART receiver. Deserialises one asynchronous frame from the serial line: start bit, 8 data bits LSB-first, optional even/odd parity bit, one stop bit. Sits behind the synchroniser on the serial input and feeds the system's register/command path. Reports a validated byte with a one-cycle strobe and flags parity and stop-bit errors.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sampler.sv | 64 ++++++
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Parity selection: PAR_EVEN expects ^data, PAR_ODD expects ~^data.
package uart_pkg;

   localparam int DATA_WIDTH     = 8;
   localparam int PRESCALE_WIDTH = 6;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timing and 3-sample majority voting for the UART receiver.
// Counters sit at zero whenever the receiver is idle, so every frame starts aligned.
module uart_rx_sampler #(
   parameter int PRESCALE_WIDTH = uart_pkg::PRESCALE_WIDTH,
   parameter int BIT_CNT_WIDTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      active,
   input  logic                      rx_in,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
   output logic                      sampled_bit,
   output logic                      sample_done,
   output logic                      bit_done
);

   import uart_pkg::*;

   logic [PRESCALE_WIDTH-1:0] edge_cnt;
   logic [PRESCALE_WIDTH-1:0] half;
   logic                      s_early;
   logic                      s_mid;
   logic                      at_early;
   logic                      at_mid;
   logic                      at_late;
   logic                      at_last;

   always_comb begin
      half     = prescale >> 1;
      at_early = (edge_cnt == half - PRESCALE_WIDTH'(1));
      at_mid   = (edge_cnt == half);
      at_late  = (edge_cnt == half + PRESCALE_WIDTH'(1));
      at_last  = (edge_cnt == prescale - PRESCALE_WIDTH'(1));
   end

   always_ff @(posedge clk) begin
      if (rst || !active) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
         s_early  <= 1'b1;
         s_mid    <= 1'b1;
      end else begin
         edge_cnt <= at_last ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
         if (at_last) begin
            bit_cnt <= bit_cnt + BIT_CNT_WIDTH'(1);
         end
         if (at_early) begin
            s_early <= rx_in;
         end
         if (at_mid) begin
            s_mid <= rx_in;
         end
      end
   end

   // The third sample is the live line value, so the vote resolves on the late tick.
   always_comb begin
      sampled_bit = (s_early & s_mid) | (s_early & rx_in) | (s_mid & rx_in);
      sample_done = active && at_late;
      bit_done    = active && at_last;
   end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_WIDTH data bits LSB-first, optional parity, one stop.
// A good frame loads p_data and strobes data_valid; bad frames only raise par_err/stp_err.
module uart_rx #(
   parameter int DATA_WIDTH     = uart_pkg::DATA_WIDTH,
   parameter int PRESCALE_WIDTH = uart_pkg::PRESCALE_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_in,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      par_en,
   input  logic                      par_typ,
   output logic [DATA_WIDTH-1:0]     p_data,
   output logic                      data_valid,
   output logic                      par_err,
   output logic                      stp_err
);

   import uart_pkg::*;

   localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 3);

   rx_state_e                 state;
   logic [PRESCALE_WIDTH-1:0] prescale_lat;
   logic                      par_en_lat;
   logic                      par_typ_lat;
   logic [DATA_WIDTH-1:0]     shift_reg;
   logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
   logic                      sampled_bit;
   logic                      sample_done;
   logic                      bit_done;
   logic                      active;
   logic                      exp_par;
   logic                      stop_bad;
   logic                      last_data_bit;

   uart_rx_sampler #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH),
      .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
   ) u_sampler (
      .clk         (clk),
      .rst         (rst),
      .active      (active),
      .rx_in       (rx_in),
      .prescale    (prescale_lat),
      .bit_cnt     (bit_cnt),
      .sampled_bit (sampled_bit),
      .sample_done (sample_done),
      .bit_done    (bit_done)
   );

   // With small prescale the stop sample and the stop bit's last tick share an edge,
   // so the frame-end decision looks at the live stop sample as well as stp_err.
   always_comb begin
      active        = (state != IDLE);
      exp_par       = (^shift_reg) ^ (par_typ_lat == PAR_ODD);
      stop_bad      = stp_err || (sample_done && !sampled_bit);
      last_data_bit = bit_done && (bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         prescale_lat <= '0;
         par_en_lat   <= 1'b0;
         par_typ_lat  <= 1'b0;
         shift_reg    <= '0;
         p_data       <= '0;
         data_valid   <= 1'b0;
         par_err      <= 1'b0;
         stp_err      <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_in) begin
                  state        <= START;
                  prescale_lat <= prescale;
                  par_en_lat   <= par_en;
                  par_typ_lat  <= par_typ;
                  par_err      <= 1'b0;
                  stp_err      <= 1'b0;
               end
            end
            START: begin
               if (sample_done && sampled_bit) begin
                  state <= IDLE;
               end else if (bit_done) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (sample_done) begin
                  shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
               end
               if (last_data_bit) begin
                  state <= par_en_lat ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (sample_done && (sampled_bit != exp_par)) begin
                  par_err <= 1'b1;
               end
               if (bit_done) begin
                  state <= STOP;
               end
            end
            STOP: begin
               if (sample_done && !sampled_bit) begin
                  stp_err <= 1'b1;
               end
               if (bit_done) begin
                  state <= IDLE;
                  if (!par_err && !stop_bad) begin
                     p_data     <= shift_reg;
                     data_valid <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame vectors from a table, a byte scoreboard
// fed when frames are sent, and hand-written glitch / back-to-back / reset sequences.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic [5:0] prescale;
   logic       par_en;
   logic       par_typ;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   int         checks = 0;
   int         passes = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   logic [7:0] last_good;
   logic [7:0] rnd_byte;
   logic       rnd_pe;
   logic       rnd_pt;

   typedef struct {
      logic [7:0] data;
      logic [5:0] prescale;
      logic       par_en;
      logic       par_typ;
      logic       par_flip;
      logic       stop_bit;
      logic       exp_valid;
      logic       exp_par_err;
      logic       exp_stp_err;
   } vec_t;

   vec_t vecs[10];

   uart_rx dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .prescale   (prescale),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Every data_valid strobe must match the oldest byte still owed by the scoreboard.
   always @(negedge clk) begin
      if (!rst && data_valid) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected data_valid", 32'd1, 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("p_data at data_valid", {24'd0, p_data}, {24'd0, mon_exp});
            checkOutput("flags at data_valid", {30'd0, par_err, stp_err}, 32'd0);
         end
      end
   end

   task automatic driveBit(input logic b, input int cycles);
      rx_in = b;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic sendFrame(input logic [7:0] data, input logic [5:0] p, input logic pe,
                            input logic pt, input logic flip, input logic stop, input int gap);
      logic pbit;
      prescale = p;
      par_en   = pe;
      par_typ  = pt;
      pbit     = (^data) ^ pt ^ flip;
      driveBit(1'b0, int'(p));
      for (int i = 0; i < 8; i++) begin
         driveBit(data[i], int'(p));
      end
      if (pe) begin
         driveBit(pbit, int'(p));
      end
      driveBit(stop, int'(p));
      if (gap > 0) begin
         driveBit(1'b1, gap);
      end
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      if (v.exp_valid) begin
         exp_q.push_back(v.data);
         last_good = v.data;
      end
      sendFrame(v.data, v.prescale, v.par_en, v.par_typ, v.par_flip, v.stop_bit, 2);
      checkOutput($sformatf("vec%0d par_err", idx), {31'd0, par_err}, {31'd0, v.exp_par_err});
      checkOutput($sformatf("vec%0d stp_err", idx), {31'd0, stp_err}, {31'd0, v.exp_stp_err});
      checkOutput($sformatf("vec%0d p_data", idx), {24'd0, p_data}, {24'd0, last_good});
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " data_valid"}, {31'd0, data_valid}, 32'd0);
      checkOutput({tag, " p_data"}, {24'd0, p_data}, 32'd0);
      checkOutput({tag, " par_err"}, {31'd0, par_err}, 32'd0);
      checkOutput({tag, " stp_err"}, {31'd0, stp_err}, 32'd0);
   endtask

   initial begin
      //          data    pre    pe    pt    flip  stop  valid perr  serr
      vecs[0] = '{8'hA5, 6'd8,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'hA5, 6'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h01, 6'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{8'h55, 6'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{8'h55, 6'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'hC3, 6'd16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{8'h7E, 6'd4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{8'h0F, 6'd32, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{8'h00, 6'd8,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[9] = '{8'hFF, 6'd6,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      rst       = 1'b1;
      rx_in     = 1'b1;
      prescale  = 6'd8;
      par_en    = 1'b0;
      par_typ   = 1'b0;
      last_good = 8'h00;
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Start glitch: 3 low clocks, then ten bit times of idle.
      driveBit(1'b0, 3);
      driveBit(1'b1, 80);
      checkAllZero("glitch");

      for (int i = 0; i < 10; i++) begin
         applyStimulus(i, vecs[i]);
      end
      checkOutput("table queue drained", exp_q.size(), 32'd0);

      // Two frames with no idle gap between them.
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hFF);
      sendFrame(8'h3C, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      sendFrame(8'hFF, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 4);
      checkOutput("back-to-back p_data", {24'd0, p_data}, 32'h0000_00FF);
      checkOutput("back-to-back queue drained", exp_q.size(), 32'd0);

      // Random stream, one idle cycle between frames.
      for (int i = 0; i < 100; i++) begin
         rnd_byte = 8'($urandom_range(0, 255));
         rnd_pe   = 1'($urandom_range(0, 1));
         rnd_pt   = 1'($urandom_range(0, 1));
         exp_q.push_back(rnd_byte);
         last_good = rnd_byte;
         sendFrame(rnd_byte, 6'd8, rnd_pe, rnd_pt, 1'b0, 1'b1, 1);
      end
      driveBit(1'b1, 4);
      checkOutput("random queue drained", exp_q.size(), 32'd0);
      checkOutput("random last p_data", {24'd0, p_data}, {24'd0, last_good});

      // Reset in the middle of a frame, then a long idle line.
      prescale = 6'd16;
      par_en   = 1'b0;
      driveBit(1'b0, 16);
      driveBit(1'b1, 16);
      driveBit(1'b0, 16);
      driveBit(1'b1, 5);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkAllZero("mid-frame reset");
      rst = 1'b0;
      driveBit(1'b1, 800);
      checkAllZero("idle line");

      exp_q.push_back(8'h81);
      sendFrame(8'h81, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 4);
      checkOutput("post-reset p_data", {24'd0, p_data}, 32'h0000_0081);
      checkOutput("post-reset queue drained", exp_q.size(), 32'd0);
      checkOutput("post-reset flags", {30'd0, par_err, stp_err}, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
